iir_inverse: RTL
================

Name: iir_inverse

Overview:
- Sequential inverse (deconvolution) filter for the 2nd-order IIR block: recovers the input sequence x[n] from the filter output y[n].
- Sits downstream of iir on the loopback/verification path.
- Solves x[n] = (y[n] + A1*y[n-1] + A2*y[n-2] - B1*x[n-1] - B2*x[n-2]) / B0.
- Uses one accumulate cycle and a 32-iteration restoring signed divider, with valid/ready handshakes on both sides.

Parameters:
- A1, 4, feedback coefficient a1 (signed 32-bit).
- A2, 3, feedback coefficient a2 (signed 32-bit).
- B0, 6, feedforward coefficient b0 (signed 32-bit). Must be nonzero; elaboration fails if B0 == 0.
- B1, 1, feedforward coefficient b1 (signed 32-bit).
- B2, 2, feedforward coefficient b2 (signed 32-bit).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- y_in  input  32  signed filter output sample y[n].
- in_valid  input  1  y_in valid.
- in_ready  output  1  block can accept a sample.
- x_out  output  32  signed recovered sample x[n].
- out_valid  output  1  x_out valid.
- out_ready  input  1  downstream accepts x_out.
- inexact  output  1  division remainder of the current x_out is nonzero. Valid with out_valid.

Behaviour:
- Reset (async, active-high) values:
  - State = IDLE; in_ready = 1; out_valid = 0; x_out = 0; inexact = 0.
  - History registers y1, y2, x1, x2 = 0; divider registers = 0.
- State machine: IDLE -> CALC -> DIV -> OUT -> IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, latch y_in and go to CALC.
- CALC (1 cycle):
  - num = y_in + A1*y1 + A2*y2 - B1*x1 - B2*x2.
  - All products and sums are truncated to 32 bits, two's complement wrap, matching the forward filter.
  - Register |num| and |B0| as 32-bit unsigned values (|-2^31| = 2^31). Record the sign of num and the sign of B0.
  - Go to DIV with iteration counter = 0.
- DIV (exactly 32 cycles):
  - One restoring shift/subtract step per cycle, MSB first.
  - On the 32nd step:
    - x_out = quotient, negated if the signs of num and B0 differ (truncation toward zero, as Verilog "/").
    - inexact = (remainder != 0).
    - out_valid <= 1; go to OUT.
- OUT:
  - x_out and inexact are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1:
    - out_valid <= 0.
    - History update: y2<=y1, y1<=latched y, x2<=x1, x1<=x_out.
    - Return to IDLE.
  - The history update uses the truncated quotient even when inexact=1.
- in_ready is high only in IDLE; it is low in CALC, DIV and OUT.
- Latency: out_valid rises 33 clock edges after the accepting edge.
- Minimum sample period: 35 cycles with out_ready tied high.
- Back-pressure: an unbounded stall in OUT is allowed; no samples are lost or duplicated.
- First sample: history is zero, so x[0] = y[0]/B0. The n=1 equation automatically drops the A2 and B2 terms.
- Quotient wrap: the -2^31 / -1 case wraps to -2^31 with inexact=0.
- Reset asserted mid-operation (any state):
  - Immediate return to the reset values above.
  - History is cleared; any sample in flight is discarded and never presented.
- in_valid or y_in changing outside IDLE has no effect.

Test Plan:
- Golden sequence:
  - Stimulus: reset, then y = 6, -11, 48, -128, 408, -1199, 3630, -10856; out_ready=1.
  - Required: x_out = 1, 2, 3, 4, 5, 6, 7, 8, with inexact=0 every sample.
  - Required: each out_valid rises exactly 33 edges after its accept.
- Back-pressure:
  - Stimulus: same sequence; hold out_ready=0 for 10 cycles on samples 2 and 5.
  - Required: x_out is stable during each stall, in_ready stays 0, and the output sequence is unchanged.
- Inexact:
  - Stimulus: after reset, y_in = 7.
  - Required: x_out = 1, inexact = 1.
  - Stimulus: next y_in = -24 + 1 = -23.
  - Required: num = -23 + 28 - 1 = 4, so x_out = 0 and inexact = 1.
- Negative truncation:
  - Stimulus: after reset, y_in = -13.
  - Required: x_out = -2 (toward zero), inexact = 1.
- Reset mid-DIV:
  - Stimulus: feed y=6, accept 2nd sample -11, assert reset 10 cycles into DIV, release, then feed y=6, -11.
  - Required: no output for the interrupted sample; afterwards x_out = 1, 2 (history was cleared).
- Handshake idle:
  - Stimulus: in_valid=0 for 50 cycles.
  - Required: in_ready=1 throughout, out_valid=0 throughout.

Source files
------------

// File: rtl/iir_inverse.sv
// Inverse of the 2nd-order IIR block: rebuilds x[n] from y[n] with one accumulate
// cycle followed by a 32-step restoring signed divide by B0.
module iir_inverse #(
    parameter int A1 = 4,
    parameter int A2 = 3,
    parameter int B0 = 6,
    parameter int B1 = 1,
    parameter int B2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] y_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [31:0] x_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               inexact
);

    if (B0 == 0) begin : g_b0_check
        $fatal(1, "iir_inverse: B0 must be nonzero");
    end

    localparam logic        B0Neg = (B0 < 0);
    localparam logic [31:0] B0Abs = (B0 < 0) ? 32'(-B0) : 32'(B0);

    typedef enum logic [1:0] {StIdle, StCalc, StDiv, StOut} state_e;

    state_e             state_q, state_d;
    logic signed [31:0] y_lat_q, y_lat_d;
    logic signed [31:0] y1_q, y1_d, y2_q, y2_d;
    logic signed [31:0] x1_q, x1_d, x2_q, x2_d;
    logic [31:0]        dvd_q, dvd_d;
    logic [31:0]        dvs_q, dvs_d;
    logic [31:0]        rem_q, rem_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic signed [31:0] x_out_q, x_out_d;
    logic               inexact_q, inexact_d;
    logic               out_valid_q, out_valid_d;

    logic signed [31:0] num;
    logic [32:0]        rem_sh;
    logic [32:0]        rem_sub;
    logic               q_bit;
    logic [31:0]        rem_next;
    logic [31:0]        quo_next;

    // Wraps at 32 bits exactly like the forward filter's arithmetic.
    always_comb begin
        num = y_lat_q + A1 * y1_q + A2 * y2_q - B1 * x1_q - B2 * x2_q;
    end

    // Dividend register shifts out MSB-first while quotient bits shift in at the LSB.
    always_comb begin
        rem_sh   = {rem_q, dvd_q[31]};
        rem_sub  = rem_sh - {1'b0, dvs_q};
        q_bit    = ~rem_sub[32];
        rem_next = q_bit ? rem_sub[31:0] : rem_sh[31:0];
        quo_next = {dvd_q[30:0], q_bit};
    end

    always_comb begin
        state_d     = state_q;
        y_lat_d     = y_lat_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        x_out_d     = x_out_q;
        inexact_d   = inexact_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    y_lat_d = y_in;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                dvd_d   = num[31] ? 32'(-num) : 32'(num);
                dvs_d   = B0Abs;
                rem_d   = '0;
                neg_d   = num[31] ^ B0Neg;
                cnt_d   = '0;
                state_d = StDiv;
            end
            StDiv: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    x_out_d     = neg_q ? 32'(-quo_next) : 32'(quo_next);
                    inexact_d   = (rem_next != '0);
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    y2_d        = y1_q;
                    y1_d        = y_lat_q;
                    x2_d        = x1_q;
                    x1_d        = x_out_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            y_lat_q     <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            x_out_q     <= '0;
            inexact_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_lat_q     <= y_lat_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            x_out_q     <= x_out_d;
            inexact_q   <= inexact_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign x_out     = x_out_q;
    assign inexact   = inexact_q;
    assign out_valid = out_valid_q;

endmodule
